// File: rtl/bicubic_line_window.sv
// bicubic_line_window
// Streaming 4-row vertical window generator for the bicubic upscaler.
// It accepts a padded RGB raster one pixel per handshake and keeps the three
// most recent rows in line buffers. From row 3 onward, every accepted pixel
// produces a registered 4-pixel column: rows r-3..r at the current column.
// Optional build macro: BICUBIC_WIN_STAT_EN adds the frame_cnt statistics port.
module bicubic_line_window #(
    parameter int IMG_WIDTH  = 963,
    parameter int IMG_HEIGHT = 543,
    parameter int DW         = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [4*DW-1:0] m_col,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_sol,
    output logic            m_eol,
`ifdef BICUBIC_WIN_STAT_EN
    output logic            m_eof,
    output logic [15:0]     frame_cnt
`else
    output logic            m_eof
`endif
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    // Rows 0..2 only prime the line buffers; nothing is emitted for them.
    localparam logic [RW-1:0] FILL_ROWS = RW'(3);
    localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;

    logic            m_valid_reg, m_valid_next;
    logic [4*DW-1:0] m_col_reg, m_col_next;
    logic            m_sol_reg, m_sol_next;
    logic            m_eol_reg, m_eol_next;
    logic            m_eof_reg, m_eof_next;

    logic in_hs;
    logic fill;
    logic last_col;
    logic last_row;
    logic load;

    // Read ports of the three line buffers, index 0 holds the oldest row.
    logic [DW-1:0] lb_rd [3];

    assign fill     = (row_reg < FILL_ROWS);
    assign last_col = (col_reg == LAST_COL);
    assign last_row = (row_reg == LAST_ROW);
    assign s_ready  = fill | ~m_valid_reg | m_ready;
    assign in_hs    = s_valid & s_ready;
    assign load     = in_hs & ~fill;

    // Raster position: column advances per accepted pixel, row at end of line.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (in_hs) begin
            if (last_col) begin
                col_next = '0;
                row_next = last_row ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // Three line buffers forming a vertical shift chain per column:
    // each buffer takes the value of the next younger one, the youngest
    // takes the incoming pixel. Contents are deliberately not reset since
    // every frame refills three rows before anything is emitted.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lb
        logic [DW-1:0] mem [IMG_WIDTH];
        logic [DW-1:0] wr_data;

        if (gi == 2) begin : g_src_in
            assign wr_data = s_data;
        end else begin : g_src_lb
            assign wr_data = lb_rd[gi+1];
        end

        // Column write on every accepted pixel; the read below sees the
        // pre-write contents, which is exactly the older row we need.
        always_ff @(posedge clk) begin
            if (in_hs) begin
                mem[col_reg] <= wr_data;
            end
        end

        assign lb_rd[gi] = mem[col_reg];
    end

    // Output register: load on an emit-phase pixel, hold under backpressure,
    // drop valid once the consumer has taken the column.
    always_comb begin
        m_col_next   = m_col_reg;
        m_sol_next   = m_sol_reg;
        m_eol_next   = m_eol_reg;
        m_eof_next   = m_eof_reg;
        m_valid_next = m_valid_reg & ~m_ready;
        if (load) begin
            m_col_next   = {s_data, lb_rd[2], lb_rd[1], lb_rd[0]};
            m_valid_next = 1'b1;
            m_sol_next   = (col_reg == '0);
            m_eol_next   = last_col;
            m_eof_next   = last_col & last_row;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_col_reg   <= '0;
            m_sol_reg   <= 1'b0;
            m_eol_reg   <= 1'b0;
            m_eof_reg   <= 1'b0;
        end else begin
            m_valid_reg <= m_valid_next;
            m_col_reg   <= m_col_next;
            m_sol_reg   <= m_sol_next;
            m_eol_reg   <= m_eol_next;
            m_eof_reg   <= m_eof_next;
        end
    end

    assign m_valid = m_valid_reg;
    assign m_col   = m_col_reg;
    assign m_sol   = m_sol_reg;
    assign m_eol   = m_eol_reg;
    assign m_eof   = m_eof_reg;

`ifdef BICUBIC_WIN_STAT_EN
    logic [15:0] frame_cnt_reg;

    // Completed-frame counter: counts delivered end-of-frame columns, wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (m_valid_reg & m_ready & m_eof_reg) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_bicubic_line_window.sv
// Testbench for bicubic_line_window on a 5x5 padded raster.
// The reference model keeps the whole fed pixel stream in an array and
// derives each expected column from raster arithmetic on the stream index.
module tb_bicubic_line_window;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int AREA = W * H;
    localparam int DW   = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic [4*DW-1:0] m_col;
    logic            m_valid;
    logic            m_ready;
    logic            m_sol;
    logic            m_eol;
    logic            m_eof;
`ifdef BICUBIC_WIN_STAT_EN
    logic [15:0]     frame_cnt;
`endif

    bicubic_line_window #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DW        (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_col    (m_col),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sol    (m_sol),
        .m_eol    (m_eol),
`ifdef BICUBIC_WIN_STAT_EN
        .m_eof    (m_eof),
        .frame_cnt(frame_cnt)
`else
        .m_eof    (m_eof)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*DW-1:0] col;
        logic            sol;
        logic            eol;
        logic            eof;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]   stream [128];
    int              g;           // pixels accepted since last reset
    exp_t            q [$];       // column expected in the output register
    logic [4*DW-1:0] out_col [$]; // delivered columns
    int              out_in [$];  // accepted-pixel count when each was delivered
    int              out_cnt;
    int              eof_cnt;
    bit              hold_pend;
    logic [4*DW-1:0] hold_col;
    logic [2:0]      hold_flg;

    task automatic chk(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*DW-1:0] col4(input int a, input int b, input int c, input int d);
        col4 = {DW'(a), DW'(b), DW'(c), DW'(d)};
    endfunction

    task automatic load_seq();
        for (int i = 0; i < 128; i++) stream[i] = DW'((i % AREA) + 1);
    endtask

    task automatic load_rand();
        for (int i = 0; i < 128; i++) stream[i] = DW'($urandom());
    endtask

    task automatic model_clear();
        g = 0;
        q.delete();
        out_col.delete();
        out_in.delete();
        out_cnt   = 0;
        eof_cnt   = 0;
        hold_pend = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_col"},   m_col,   0);
        chk({tag, "_flags"},   {m_sol, m_eol, m_eof}, 0);
        chk({tag, "_s_ready"}, s_ready, 1);
`ifdef BICUBIC_WIN_STAT_EN
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
`endif
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input bit v, input bit rdy);
        int   pos;
        bit   exp_ready;
        exp_t e;
        s_valid = v;
        m_ready = rdy;
        s_data  = v ? stream[g] : DW'($urandom());
        #1;
`ifdef BICUBIC_WIN_STAT_EN
        chk("frame_cnt", frame_cnt, eof_cnt);
`endif
        if (hold_pend) begin
            chk("hold_col",   m_col, hold_col);
            chk("hold_flags", {m_sol, m_eol, m_eof}, hold_flg);
        end
        chk("m_valid", m_valid, (q.size() != 0));
        pos       = g % AREA;
        exp_ready = ((pos / W) < 3) || (q.size() == 0) || rdy;
        chk("s_ready", s_ready, exp_ready);
        if (m_valid && rdy && q.size() != 0) begin
            e = q.pop_front();
            chk("out_col",   m_col, e.col);
            chk("out_flags", {m_sol, m_eol, m_eof}, {e.sol, e.eol, e.eof});
            out_col.push_back(m_col);
            out_in.push_back(g);
            out_cnt++;
            if (m_eof) eof_cnt++;
        end
        hold_pend = m_valid && !rdy;
        hold_col  = m_col;
        hold_flg  = {m_sol, m_eol, m_eof};
        if (v && exp_ready) begin
            if ((pos / W) >= 3) begin
                e.col = {stream[g], stream[g-W], stream[g-2*W], stream[g-3*W]};
                e.sol = (pos % W) == 0;
                e.eol = (pos % W) == W - 1;
                e.eof = (pos == AREA - 1);
                q.push_back(e);
            end
            g++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            step(0, 1);
            n++;
        end
        step(0, 1);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;

        // Reset state
        load_seq();
        do_reset();
        check_reset_state("reset");

        // Continuous stream with consumer always ready
        for (int i = 0; i < AREA; i++) step(1, 1);
        drain();
        chk("t1_count", out_cnt, 10);
        if (out_col.size() == 10) begin
            chk("t1_first", out_col[0], col4(16, 11, 6, 1));
            chk("t1_last",  out_col[9], col4(25, 20, 15, 10));
        end
        chk("t1_eof_cnt", eof_cnt, 1);

        // Backpressure from the second output onward
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 1);
        for (int i = 0; i < 4; i++) step(1, 0);
        chk("t2_hold_col",  m_col,   col4(17, 12, 7, 2));
        chk("t2_hold_srdy", s_ready, 0);
        while (g < AREA && out_cnt < 20) step(1, 1);
        drain();
        chk("t2_count", out_cnt, 10);
        if (out_col.size() == 10) begin
            chk("t2_out1", out_col[1], col4(17, 12, 7, 2));
            chk("t2_out2", out_col[2], col4(18, 13, 8, 3));
        end

        // Consumer stalled from reset: fill proceeds, pixel 16 accepted, then stall
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0);
        chk("t3_srdy",  s_ready, 0);
        chk("t3_col",   m_col,   col4(16, 11, 6, 1));
        chk("t3_valid", m_valid, 1);
        while (g < AREA && out_cnt < 20) step(1, 1);
        drain();
        chk("t3_count", out_cnt, 10);

        // Two frames back to back
        do_reset();
        for (int i = 0; i < 2 * AREA; i++) step(1, 1);
        drain();
        chk("t4_count", out_cnt, 20);
        if (out_col.size() == 20) begin
            chk("t4_gap",    out_in[10] - out_in[9], 16);
            chk("t4_f2_col", out_col[10], col4(16, 11, 6, 1));
            chk("t4_f2_end", out_col[19], col4(25, 20, 15, 10));
        end

        // Reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 18; i++) step(1, 1);
        do_reset();
        check_reset_state("t5_rst");
        for (int i = 0; i < AREA; i++) step(1, 1);
        drain();
        chk("t5_count", out_cnt, 10);
        if (out_col.size() == 10) begin
            chk("t5_first", out_col[0], col4(16, 11, 6, 1));
            chk("t5_first_in", out_in[0], 16);
        end

        // Random data, random valid and ready over three frames
        load_rand();
        do_reset();
        begin
            int n = 0;
            while (g < 3 * AREA && n < 3000) begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
                n++;
            end
        end
        chk("t6_accepted", g, 3 * AREA);
        drain();
        chk("t6_count", out_cnt, 30);
        chk("t6_eofs",  eof_cnt, 3);
`ifdef BICUBIC_WIN_STAT_EN
        chk("t6_frame_cnt", frame_cnt, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
